uart_tx_framer: RTL and testbench
=================================

Name: uart_tx_framer

Overview:
- Transmit-side UART framer; sits directly downstream of the TX parity generator.
- Accepts an 8-bit byte on a start strobe and drives the generator's load_data during acceptance.
- Captures the returned PARITY_BIT and serialises the frame onto the TX line: start, 8 data bits LSB first, optional parity, 1 or 2 stop bits.
- Contains its own bit-period counter.

Parameters:
- CLKS_PER_BIT, 16, clock cycles per serial bit; legal range 2..65535.
- PARITY_EN, 1, 1 = insert parity bit after data; 0 = no parity slot.
- PARITY_ODD, 0, 1 = transmit inverted PARITY_BIT (odd parity); 0 = transmit PARITY_BIT as-is (even parity).
- STOP_BITS, 1, number of stop bits; legal values 1 or 2.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- rst_n  in  1  synchronous active-low reset, sampled on rising clk.
- TX_DATA  in  8  byte to send; also routed to the parity generator's TX_DATA input; sampled only in the accept cycle.
- tx_start  in  1  request strobe; honoured only in IDLE.
- PARITY_BIT  in  1  from the parity generator; sampled only in the accept cycle.
- load_data  out  1  to the parity generator; combinational = (state==IDLE) & tx_start.
- TX  out  1  serial line, registered, idles high.
- tx_busy  out  1  registered; high while a frame is on the line.
- tx_done  out  1  registered one-cycle pulse when a frame completes.

Behaviour:
- Reset (rst_n low at a rising edge):
  - TX=1, tx_busy=0, tx_done=0, state=IDLE, counters cleared.
  - load_data=0 while in reset.
  - Reset mid-frame abandons the frame; TX is 1 the cycle after the reset edge.
- States: IDLE, START, DATA, PARITY, STOP.
- Accept cycle T0 (state IDLE and tx_start=1):
  - load_data=1.
  - Shift register <= TX_DATA.
  - par_q <= PARITY_BIT ^ PARITY_ODD.
  - Bit counter cleared; next state START.
- Frame timing:
  - From T0+1, TX=0 for CLKS_PER_BIT cycles.
  - Then each data bit D0..D7 for CLKS_PER_BIT cycles each.
  - Then par_q for CLKS_PER_BIT cycles if PARITY_EN=1 (PARITY state skipped if 0).
  - Then TX=1 for STOP_BITS*CLKS_PER_BIT cycles.
- Frame length: N = (1+8+PARITY_EN+STOP_BITS)*CLKS_PER_BIT cycles, spanning T0+1..T0+N.
- Bit-period counter: counts 0..CLKS_PER_BIT-1; wraps to 0 on its terminal count, which advances the bit or state. Width = clog2(CLKS_PER_BIT).
- Data bit index: 0..7; DATA→PARITY/STOP transition when index 7 hits terminal count.
- STOP bit index: 0..STOP_BITS-1; on the final terminal count, next state IDLE.
- Completion cycle T0+N+1:
  - tx_done=1 (one cycle only), tx_busy=0, state IDLE, TX=1.
  - tx_start in this cycle is accepted, so back-to-back frames have zero idle gap: next START begins at T0+N+2.
- tx_busy: high T0+1..T0+N inclusive.
- tx_start while not in IDLE: ignored, no queuing; load_data stays 0.
- TX_DATA / PARITY_BIT changes after T0: no effect on the frame in flight.
- tx_start held high continuously: a new frame starts at every completion cycle.

Decomposition:
- Package uart_pkg:
  - Framer state enum (IDLE, START, DATA, PARITY, STOP).
  - UART_DATA_BITS=8.
  - Line-level constants UART_IDLE_LVL=1, UART_START_LVL=0.
- Sub-module uart_baud_counter (parameter CLKS_PER_BIT; inputs clk, rst_n, clear; output tick on terminal count).
  - Same counter to be reused by the future receiver.
- The parity generator stays external; the framer never recomputes parity.

Test Plan:
- CLKS_PER_BIT=4, PARITY_EN=1, even, STOP_BITS=1; send 0xA5 with PARITY_BIT=0 -> TX bit sequence 0,1,0,1,0,0,1,0,1,0,1, each held 4 cycles; tx_busy high 44 cycles; tx_done pulse at T0+45; load_data high only at T0.
- Same config, 0x07 with PARITY_BIT=1 -> parity slot=1; PARITY_ODD=1 with 0xA5/PARITY_BIT=0 -> parity slot=1.
- PARITY_EN=0, STOP_BITS=2, 0x3C -> 0,0,0,1,1,1,1,0,0,1,1; 44 cycles busy; no parity slot.
- Back-to-back: tx_start held high, bytes 0x55 then 0xAA -> second start bit begins at T0+46; TX never high between frames except stop bit(s); two tx_done pulses.
- tx_start pulsed mid-frame (T0+10) with TX_DATA=0xFF -> ignored; frame content unchanged, load_data stays 0.
- rst_n low at T0+20 for one cycle -> TX=1, tx_busy=0, tx_done=0 next cycle; new tx_start afterwards produces a clean full frame.

Source files
------------

// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// uart_pkg : shared UART types and line-level constants
// Rev 1.0
// ============================================================================
package uart_pkg;

   localparam int   UART_DATA_BITS = 8;
   localparam logic UART_IDLE_LVL  = 1'b1;
   localparam logic UART_START_LVL = 1'b0;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP   = 3'd4
   } framer_state_e;

endpackage
`default_nettype wire

// File: rtl/uart_tx_framer_if.sv
`default_nettype none
// ============================================================================
// uart_tx_framer_if : byte/parity handshake and serial outputs of the TX framer
// Rev 1.0
// ============================================================================
interface uart_tx_framer_if;

   logic [uart_pkg::UART_DATA_BITS-1:0] TX_DATA;
   logic                                tx_start;
   logic                                PARITY_BIT;
   logic                                load_data;
   logic                                TX;
   logic                                tx_busy;
   logic                                tx_done;

   modport master (
      output TX_DATA, tx_start, PARITY_BIT,
      input  load_data, TX, tx_busy, tx_done
   );

   modport slave (
      input  TX_DATA, tx_start, PARITY_BIT,
      output load_data, TX, tx_busy, tx_done
   );

endinterface
`default_nettype wire

// File: rtl/uart_baud_counter.sv
`default_nettype none
// ============================================================================
// uart_baud_counter : bit-period counter, ticks on the last clock of each bit
// Rev 1.0
// ============================================================================
module uart_baud_counter #(
   parameter int CLKS_PER_BIT = 16
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   output logic tick
);

   localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CNT_W-1:0] C_TERMINAL = CNT_W'(CLKS_PER_BIT - 1);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   assign tick = (cnt_q == C_TERMINAL);

   always_comb begin
      cnt_d = cnt_q + 1'b1;
      if (clear || tick) begin
         cnt_d = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule
`default_nettype wire

// File: rtl/uart_tx_framer.sv
`default_nettype none
// ============================================================================
// uart_tx_framer : serialises start, 8 data bits LSB first, parity, stop bits
// Rev 1.0
// ============================================================================
module uart_tx_framer
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = 16,
   parameter int PARITY_EN    = 1,
   parameter int PARITY_ODD   = 0,
   parameter int STOP_BITS    = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   uart_tx_framer_if.slave  bus
);

   localparam logic [2:0] C_LAST_DATA = 3'(UART_DATA_BITS - 1);
   localparam logic [2:0] C_LAST_STOP = 3'(STOP_BITS - 1);
   localparam logic       C_PAR_INV   = (PARITY_ODD != 0);

   framer_state_e                 state_q;
   logic [UART_DATA_BITS-1:0]     shreg_q;
   logic                          par_q;
   logic [2:0]                    idx_q;
   logic                          tx_q;
   logic                          busy_q;
   logic                          done_q;
   logic                          tick;
   logic                          baud_clear;

   // Gated by rst_n so the parity generator never loads during reset.
   assign bus.load_data = rst_n && (state_q == ST_IDLE) && bus.tx_start;
   assign bus.TX        = tx_q;
   assign bus.tx_busy   = busy_q;
   assign bus.tx_done   = done_q;

   assign baud_clear = (state_q == ST_IDLE);

   uart_baud_counter #(
      .CLKS_PER_BIT (CLKS_PER_BIT)
   ) u_baud (
      .clk   (clk),
      .rst_n (rst_n),
      .clear (baud_clear),
      .tick  (tick)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         shreg_q <= '0;
         par_q   <= 1'b0;
         idx_q   <= '0;
         tx_q    <= UART_IDLE_LVL;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               tx_q <= UART_IDLE_LVL;
               if (bus.tx_start) begin
                  shreg_q <= bus.TX_DATA;
                  par_q   <= bus.PARITY_BIT ^ C_PAR_INV;
                  idx_q   <= '0;
                  tx_q    <= UART_START_LVL;
                  busy_q  <= 1'b1;
                  state_q <= ST_START;
               end
            end
            ST_START: begin
               if (tick) begin
                  tx_q    <= shreg_q[0];
                  shreg_q <= shreg_q >> 1;
                  idx_q   <= '0;
                  state_q <= ST_DATA;
               end
            end
            ST_DATA: begin
               if (tick) begin
                  if (idx_q == C_LAST_DATA) begin
                     idx_q <= '0;
                     if (PARITY_EN != 0) begin
                        tx_q    <= par_q;
                        state_q <= ST_PARITY;
                     end else begin
                        tx_q    <= UART_IDLE_LVL;
                        state_q <= ST_STOP;
                     end
                  end else begin
                     // D0 already left at the START tick, so each tick emits the next bit.
                     tx_q    <= shreg_q[0];
                     shreg_q <= shreg_q >> 1;
                     idx_q   <= idx_q + 3'd1;
                  end
               end
            end
            ST_PARITY: begin
               if (tick) begin
                  tx_q    <= UART_IDLE_LVL;
                  idx_q   <= '0;
                  state_q <= ST_STOP;
               end
            end
            ST_STOP: begin
               if (tick) begin
                  if (idx_q == C_LAST_STOP) begin
                     busy_q  <= 1'b0;
                     done_q  <= 1'b1;
                     state_q <= ST_IDLE;
                  end else begin
                     idx_q <= idx_q + 3'd1;
                  end
               end
            end
            default: begin
               tx_q    <= UART_IDLE_LVL;
               busy_q  <= 1'b0;
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_framer.sv
`default_nettype none
// ============================================================================
// tb_uart_tx_framer : three framer configurations driven by one random stream
// Rev 1.0
// ============================================================================
module tb_uart_tx_framer;

   localparam int NCFG = 3;
   localparam int CPB  = 4;

   typedef struct packed {
      logic [15:0] bits;
      int          s;
   } frame_t;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       tx_start;
   logic [7:0] tx_data;
   logic       par_bit;
   int         cyc = 0;
   int         tests = 0;
   int         fails = 0;
   bit         end_chk = 1'b0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input int cfg, input string name, input logic [31:0] got, input logic [31:0] req);
      tests++;
      if (got !== req) begin
         fails++;
         $display("FAIL cfg%0d %s at cycle %0d: got %0h, required %0h", cfg, name, cyc, got, req);
      end
   endtask

   // Expected line levels, one entry per serial bit slot, bit 0 sent first.
   function automatic frame_t mk_frame(input logic [7:0] d, input logic p, input int pe,
                                       input int po, input int sb, input int s);
      frame_t f;
      int     n;
      f.bits = '0;
      f.s    = s;
      n      = 0;
      f.bits[n] = 1'b0; n++;
      for (int i = 0; i < 8; i++) begin f.bits[n] = d[i]; n++; end
      if (pe != 0) begin f.bits[n] = p ^ (po != 0); n++; end
      for (int k = 0; k < sb; k++) begin f.bits[n] = 1'b1; n++; end
      return f;
   endfunction

   generate
      for (genvar gi = 0; gi < NCFG; gi++) begin : g_cfg
         localparam int PE   = (gi == 2) ? 0 : 1;
         localparam int PO   = (gi == 1) ? 1 : 0;
         localparam int SB   = (gi == 2) ? 2 : 1;
         localparam int NCYC = (1 + 8 + PE + SB) * CPB;

         uart_tx_framer_if bus();
         assign bus.TX_DATA    = tx_data;
         assign bus.tx_start   = tx_start;
         assign bus.PARITY_BIT = par_bit;

         uart_tx_framer #(
            .CLKS_PER_BIT (CPB),
            .PARITY_EN    (PE),
            .PARITY_ODD   (PO),
            .STOP_BITS    (SB)
         ) u_dut (
            .clk   (clk),
            .rst_n (rst_n),
            .bus   (bus)
         );

         frame_t exp_q[$];
         int     busy_until = -1;
         int     err = 0;
         bit     armed = 1'b0;
         bit     rst_pend = 1'b0;

         // Reference model: decides acceptance from its own notion of busy time.
         always @(negedge clk) begin : mdl
            logic exp_ld;
            #2;
            exp_ld = rst_n && tx_start && (cyc > busy_until);
            chk(gi, "load_data", {31'd0, bus.load_data}, {31'd0, exp_ld});
            if (!rst_n) begin
               exp_q.delete();
               busy_until = cyc;
               err        = 0;
               armed      = 1'b1;
               rst_pend   = 1'b1;
            end else if (exp_ld) begin
               exp_q.push_back(mk_frame(tx_data, par_bit, PE, PO, SB, cyc + 1));
               busy_until = cyc + NCYC;
            end
         end

         // Monitor: compares line state against the scoreboard head every cycle.
         always @(negedge clk) begin : mon
            int off;
            if (rst_pend) begin
               chk(gi, "reset_state", {29'd0, bus.TX, bus.tx_busy, bus.tx_done}, 32'b100);
               rst_pend = 1'b0;
            end
            if (armed) begin
               if (exp_q.size() > 0 && cyc >= exp_q[0].s) begin
                  off = cyc - exp_q[0].s;
                  if (off < NCYC) begin
                     if (bus.TX !== exp_q[0].bits[off / CPB] || bus.tx_busy !== 1'b1 ||
                         bus.tx_done !== 1'b0)
                        err++;
                  end else begin
                     chk(gi, "frame_mismatch_cycles", err, 0);
                     chk(gi, "completion_tx_busy_done", {29'd0, bus.TX, bus.tx_busy, bus.tx_done}, 32'b101);
                     void'(exp_q.pop_front());
                     err = 0;
                  end
               end else begin
                  chk(gi, "idle_tx_busy_done", {29'd0, bus.TX, bus.tx_busy, bus.tx_done}, 32'b100);
               end
            end
         end

         initial begin
            wait (end_chk);
            chk(gi, "frames_left_in_queue", exp_q.size(), 0);
         end
      end
   endgenerate

   task automatic drive(input bit s, input logic [7:0] d, input bit p, input bit r);
      @(negedge clk);
      tx_start = s;
      tx_data  = d;
      par_bit  = p;
      rst_n    = r;
   endtask

   task automatic idle(input int n);
      repeat (n) drive(1'b0, 8'($urandom), 1'($urandom), 1'b1);
   endtask

   initial begin
      rst_n    = 1'b0;
      tx_start = 1'b0;
      tx_data  = 8'h00;
      par_bit  = 1'b0;
      repeat (3) drive(1'b0, 8'h00, 1'b0, 1'b0);
      idle(3);

      // 0xA5 with a stray start request at T0+10
      drive(1'b1, 8'hA5, 1'b0, 1'b1);
      idle(9);
      drive(1'b1, 8'hFF, 1'b1, 1'b1);
      idle(50);

      drive(1'b1, 8'h07, 1'b1, 1'b1);
      idle(50);
      drive(1'b1, 8'h3C, 1'b0, 1'b1);
      idle(50);

      // Back-to-back: start held through the first completion cycle
      drive(1'b1, 8'h55, 1'b0, 1'b1);
      repeat (45) drive(1'b1, 8'hAA, 1'b0, 1'b1);
      idle(50);

      // Reset at T0+20 with a start request pending, then a clean frame
      drive(1'b1, 8'hC3, 1'b0, 1'b1);
      idle(19);
      drive(1'b1, 8'hFF, 1'b1, 1'b0);
      idle(3);
      drive(1'b1, 8'h96, 1'b0, 1'b1);
      idle(50);

      repeat (1500)
         drive(($urandom_range(0, 7) == 0), 8'($urandom), 1'($urandom), ($urandom_range(0, 399) != 0));
      idle(60);

      end_chk = 1'b1;
      #1;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
`default_nettype wire
